// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared definitions for the MM:SS countdown timer:
//   state_t          - timer state encoding (IDLE / RUN / PAUSED / DONE)
//   BCD_MAX_UNITS    - largest value of a units digit or minute-tens digit (9)
//   BCD_MAX_TENS_SEC - largest value of the seconds-tens digit (5)
//   DIG_*            - position of each digit in the packed time vector
//   clamp_digit()    - saturate a BCD digit to its legal maximum
// -----------------------------------------------------------------------------
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

   // Digit 0 is the least significant (seconds units); the borrow ripples up.
   localparam int NUM_DIGITS = 4;
   localparam int DIG_SEC_O  = 0;
   localparam int DIG_SEC_T  = 1;
   localparam int DIG_MIN_O  = 2;
   localparam int DIG_MIN_T  = 3;

   function automatic logic [3:0] clamp_digit(input logic [3:0] value,
                                              input logic [3:0] limit);
      return (value > limit) ? limit : value;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// -----------------------------------------------------------------------------
// bcd_digit_down
// One BCD digit of a down-counter, purely combinational.
//   MAX        - value the digit wraps to when it is decremented from 0
//   digit      - current digit value
//   enable     - decrement request (tick, or borrow from the digit below)
//   next_digit - digit value after the (optional) decrement
//   borrow     - high when the digit wrapped 0 -> MAX, i.e. the digit above
//                must decrement too
// -----------------------------------------------------------------------------
module bcd_digit_down
   import countdown_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
   input  logic [3:0] digit,
   input  logic       enable,
   output logic [3:0] next_digit,
   output logic       borrow
);

   always_comb begin
      next_digit = digit;
      borrow     = 1'b0;
      if (enable) begin
         if (digit == 4'd0) begin
            next_digit = MAX;
            borrow     = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// MM:SS BCD countdown timer driven by a 1 Hz square wave.
//   DONE_HOLD_S - number of 1 Hz ticks DONE is held before returning to IDLE
// Ports:
//   clk_50MHz             - system clock
//   set_n                 - asynchronous active-high reset
//   clk_1Hz               - 1 Hz square wave, synchronous to clk_50MHz
//   load                  - strobe: capture load_* digits, go to IDLE
//   load_min_t..load_sec_o- BCD preset (clamped to 99:59)
//   start                 - strobe: begin or resume counting
//   pause                 - strobe: freeze counting while running
//   min_t..sec_o          - current time, BCD, registered
//   running               - high while counting
//   done                  - high while the expired time is being held
// -----------------------------------------------------------------------------
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int DONE_HOLD_S = 5
) (
   input  logic       clk_50MHz,
   input  logic       set_n,
   input  logic       clk_1Hz,
   input  logic       load,
   input  logic [3:0] load_min_t,
   input  logic [3:0] load_min_o,
   input  logic [3:0] load_sec_t,
   input  logic [3:0] load_sec_o,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] min_t,
   output logic [3:0] min_o,
   output logic [3:0] sec_t,
   output logic [3:0] sec_o,
   output logic       running,
   output logic       done
);

   // The hold counter runs 0 .. DONE_HOLD_S-1 inside DONE.
   localparam int HOLD_W = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((DONE_HOLD_S > 0) ? DONE_HOLD_S - 1 : 0);

   state_t                          state_reg;
   logic [NUM_DIGITS-1:0][3:0]      digit_reg;
   logic [HOLD_W-1:0]               hold_cnt_reg;
   logic                            clk_1hz_reg;
   logic                            running_reg;
   logic                            done_reg;

   logic                            tick;
   logic [NUM_DIGITS-1:0][3:0]      digit_dec;
   logic [NUM_DIGITS:0]             borrow_chain;
   logic [NUM_DIGITS-1:0][3:0]      load_raw;
   logic [NUM_DIGITS-1:0][3:0]      load_clamped;
   logic                            time_zero;
   logic                            dec_zero;

   // Tick is high for the single clk_50MHz cycle in which clk_1Hz is first
   // seen high; it acts on the clock edge that ends that cycle.
   assign tick = clk_1Hz & ~clk_1hz_reg;

   // Decrement only ever starts at the seconds-units digit while running.
   assign borrow_chain[0] = tick && (state_reg == ST_RUN);

   assign load_raw = {load_min_t, load_min_o, load_sec_t, load_sec_o};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         localparam logic [3:0] DIGIT_MAX =
            (gi == DIG_SEC_T) ? BCD_MAX_TENS_SEC : BCD_MAX_UNITS;

         bcd_digit_down #(
            .MAX        (DIGIT_MAX)
         ) u_digit (
            .digit      (digit_reg[gi]),
            .enable     (borrow_chain[gi]),
            .next_digit (digit_dec[gi]),
            .borrow     (borrow_chain[gi+1])
         );

         assign load_clamped[gi] = clamp_digit(load_raw[gi], DIGIT_MAX);
      end
   endgenerate

   assign time_zero = (digit_reg == '0);
   assign dec_zero  = (digit_dec == '0);

   always_ff @(posedge clk_50MHz or posedge set_n) begin
      if (set_n) begin
         state_reg    <= ST_IDLE;
         digit_reg    <= '0;
         hold_cnt_reg <= '0;
         clk_1hz_reg  <= 1'b0;
         running_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         clk_1hz_reg <= clk_1Hz;

         if (load) begin
            // Load overrides any start/pause arriving in the same cycle.
            digit_reg    <= load_clamped;
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
         end else begin
            case (state_reg)
               ST_RUN: begin
                  if (pause) begin
                     // Pause wins over a coincident tick: time stays frozen.
                     state_reg   <= ST_PAUSED;
                     running_reg <= 1'b0;
                  end else if (tick) begin
                     if (borrow_chain[NUM_DIGITS]) begin
                        // Would wrap past 00:00; stop at zero instead.
                        state_reg    <= ST_DONE;
                        hold_cnt_reg <= '0;
                        running_reg  <= 1'b0;
                        done_reg     <= 1'b1;
                     end else begin
                        digit_reg <= digit_dec;
                        if (dec_zero) begin
                           state_reg    <= ST_DONE;
                           hold_cnt_reg <= '0;
                           running_reg  <= 1'b0;
                           done_reg     <= 1'b1;
                        end
                     end
                  end
               end

               default: begin
                  // IDLE, PAUSED and DONE all honour start the same way; a
                  // start at 00:00 (re)enters DONE with a fresh hold period.
                  if (start) begin
                     hold_cnt_reg <= '0;
                     if (time_zero) begin
                        state_reg   <= ST_DONE;
                        running_reg <= 1'b0;
                        done_reg    <= 1'b1;
                     end else begin
                        state_reg   <= ST_RUN;
                        running_reg <= 1'b1;
                        done_reg    <= 1'b0;
                     end
                  end else if ((state_reg == ST_DONE) && tick) begin
                     if (hold_cnt_reg >= HOLD_LAST) begin
                        state_reg    <= ST_IDLE;
                        hold_cnt_reg <= '0;
                        done_reg     <= 1'b0;
                     end else begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign min_t   = digit_reg[DIG_MIN_T];
   assign min_o   = digit_reg[DIG_MIN_O];
   assign sec_t   = digit_reg[DIG_SEC_T];
   assign sec_o   = digit_reg[DIG_SEC_O];
   assign running = running_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Self-checking bench for countdown_timer: a table of directed vectors, two
// hand-written corner sequences (pause on a tick, reset mid-run) and a
// randomized run compared against a seconds-based reference model.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int HOLD = 5;

   logic       clk_50MHz = 1'b0;
   logic       set_n;
   logic       clk_1Hz;
   logic       load;
   logic [3:0] load_min_t, load_min_o, load_sec_t, load_sec_o;
   logic       start;
   logic       pause;
   logic [3:0] min_t, min_o, sec_t, sec_o;
   logic       running;
   logic       done;

   always #5 clk_50MHz = ~clk_50MHz;

   countdown_timer #(
      .DONE_HOLD_S (HOLD)
   ) dut (
      .clk_50MHz   (clk_50MHz),
      .set_n       (set_n),
      .clk_1Hz     (clk_1Hz),
      .load        (load),
      .load_min_t  (load_min_t),
      .load_min_o  (load_min_o),
      .load_sec_t  (load_sec_t),
      .load_sec_o  (load_sec_o),
      .start       (start),
      .pause       (pause),
      .min_t       (min_t),
      .min_o       (min_o),
      .sec_t       (sec_t),
      .sec_o       (sec_o),
      .running     (running),
      .done        (done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model: time kept as plain seconds ----------
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   int m_secs;
   int m_state;
   int m_hold;
   bit m_prev;

   function automatic int lim(input logic [3:0] d, input int mx);
      return (int'(d) > mx) ? mx : int'(d);
   endfunction

   function automatic void model_reset();
      m_secs  = 0;
      m_state = M_IDLE;
      m_hold  = 0;
      m_prev  = 1'b0;
   endfunction

   function automatic void model_step(input bit ld, input logic [15:0] bcd,
                                      input bit st, input bit pa, input bit c1);
      bit tk;
      tk     = c1 && !m_prev;
      m_prev = c1;
      if (ld) begin
         m_secs  = (10 * lim(bcd[15:12], 9) + lim(bcd[11:8], 9)) * 60
                 + 10 * lim(bcd[7:4], 5) + lim(bcd[3:0], 9);
         m_state = M_IDLE;
         m_hold  = 0;
      end else if (m_state == M_RUN) begin
         if (pa) m_state = M_PAUSED;
         else if (tk) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
               m_state = M_DONE;
               m_hold  = 0;
            end
         end
      end else if (st) begin
         m_hold  = 0;
         m_state = (m_secs != 0) ? M_RUN : M_DONE;
      end else if (m_state == M_DONE && tk) begin
         m_hold = m_hold + 1;
         if (m_hold >= HOLD) begin
            m_state = M_IDLE;
            m_hold  = 0;
         end
      end
   endfunction

   function automatic logic [15:0] model_bcd();
      int mins, s;
      mins = m_secs / 60;
      s    = m_secs % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   // ---------------- directed vector table --------------------------------
   typedef struct {
      bit          ld;
      logic [15:0] ld_bcd;
      bit          st;
      bit          pa;
      bit          c1;
      logic [15:0] exp_bcd;
      bit          er;
      bit          ed;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit ld, input logic [15:0] lb, input bit st,
                               input bit pa, input bit c1, input logic [15:0] eb,
                               input bit er, input bit ed);
      vec_t v;
      v.ld = ld; v.ld_bcd = lb; v.st = st; v.pa = pa; v.c1 = c1;
      v.exp_bcd = eb; v.er = er; v.ed = ed;
      vecs.push_back(v);
   endfunction

   // ---------------- drive / check helpers --------------------------------
   // Called at posedge+1: inputs settle, then one clock edge, then sample.
   task automatic drive(input bit ld, input logic [15:0] bcd, input bit st,
                        input bit pa, input bit c1);
      load = ld;
      {load_min_t, load_min_o, load_sec_t, load_sec_o} = bcd;
      start   = st;
      pause   = pa;
      clk_1Hz = c1;
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] eb,
                        input bit er, input bit ed);
      logic [15:0] got;
      got = {min_t, min_o, sec_t, sec_o};
      n_cmp++;
      if (got !== eb || running !== er || done !== ed) begin
         n_bad++;
         $display("FAIL %s: got %h%h:%h%h run=%b done=%b, required %h%h:%h%h run=%b done=%b",
                  name, got[15:12], got[11:8], got[7:4], got[3:0], running, done,
                  eb[15:12], eb[11:8], eb[7:4], eb[3:0], er, ed);
      end else begin
         $display("ok   %s: %h%h:%h%h run=%b done=%b",
                  name, got[15:12], got[11:8], got[7:4], got[3:0], running, done);
      end
   endtask

   task automatic do_reset();
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      set_n = 1'b1;
      @(posedge clk_50MHz);
      #1;
      set_n = 1'b0;
      model_reset();
   endtask

   // ---------------- test sequence ----------------------------------------
   initial begin
      bit          rc1;
      bit          rld, rst, rpa;
      logic [15:0] rbcd;

      set_n = 1'b1;
      clk_1Hz = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      {load_min_t, load_min_o, load_sec_t, load_sec_o} = 16'h0000;
      @(posedge clk_50MHz);
      @(posedge clk_50MHz);
      #1;
      check("reset_state", 16'h0000, 1'b0, 1'b0);
      set_n = 1'b0;

      //   ld  load      st pa c1  expect   run done
      add(1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0);  // load 01:00
      add(0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0);  // start
      add(0, 16'h0000, 0, 0, 1, 16'h0059, 1, 0);  // tick -> 00:59
      add(0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0);
      add(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0);  // load 10:00
      add(0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0);
      add(0, 16'h0000, 0, 0, 1, 16'h0959, 1, 0);  // full borrow chain
      add(0, 16'h0000, 0, 0, 0, 16'h0959, 1, 0);
      add(1, 16'hFFFF, 0, 0, 0, 16'h9959, 0, 0);  // clamped load
      add(0, 16'h0000, 0, 0, 1, 16'h9959, 0, 0);  // tick in IDLE: no change
      add(0, 16'h0000, 0, 0, 0, 16'h9959, 0, 0);
      add(1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0);  // load 00:02
      add(0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0);
      add(0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0);
      add(0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);  // reaches zero -> DONE
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);  // hold tick 1
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);  // hold tick 2
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);  // hold tick 3
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1);  // hold tick 4
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1);
      add(0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);  // hold tick 5 -> IDLE
      add(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
      add(0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1);  // start at 00:00 -> DONE
      add(1, 16'h0003, 1, 1, 0, 16'h0003, 0, 0);  // load beats start/pause
      add(0, 16'h0000, 1, 1, 0, 16'h0003, 1, 0);  // both outside RUN = start
      add(0, 16'h0000, 0, 1, 0, 16'h0003, 0, 0);  // pause -> PAUSED
      add(0, 16'h0000, 0, 1, 0, 16'h0003, 0, 0);  // pause ignored
      add(0, 16'h0000, 1, 0, 0, 16'h0003, 1, 0);  // resume

      foreach (vecs[i]) begin
         drive(vecs[i].ld, vecs[i].ld_bcd, vecs[i].st, vecs[i].pa, vecs[i].c1);
         check($sformatf("vec%0d", i), vecs[i].exp_bcd, vecs[i].er, vecs[i].ed);
      end

      // ---- pause coincident with a tick at 00:30 ----
      do_reset();
      drive(1, 16'h0031, 0, 0, 0);
      drive(0, 16'h0000, 1, 0, 0);
      drive(0, 16'h0000, 0, 0, 1);
      check("pause_pre", 16'h0030, 1'b1, 1'b0);
      drive(0, 16'h0000, 0, 0, 0);
      drive(0, 16'h0000, 0, 1, 1);
      check("pause_on_tick", 16'h0030, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 16'h0000, 0, 0, 0);
         drive(0, 16'h0000, 0, 0, 1);
         check($sformatf("paused_hold%0d", k), 16'h0030, 1'b0, 1'b0);
      end
      drive(0, 16'h0000, 0, 0, 0);
      drive(0, 16'h0000, 1, 0, 0);
      check("resume", 16'h0030, 1'b1, 1'b0);
      drive(0, 16'h0000, 0, 0, 1);
      check("resume_tick", 16'h0029, 1'b1, 1'b0);

      // ---- reset asserted mid-run at 05:17 ----
      do_reset();
      drive(1, 16'h0518, 0, 0, 0);
      drive(0, 16'h0000, 1, 0, 0);
      drive(0, 16'h0000, 0, 0, 1);
      check("run_0517", 16'h0517, 1'b1, 1'b0);
      #3;
      set_n = 1'b1;
      #1;
      check("rst_async", 16'h0000, 1'b0, 1'b0);
      @(posedge clk_50MHz);
      #1;
      set_n = 1'b0;
      drive(0, 16'h0000, 0, 0, 1);   // first tick after release
      check("post_rst_tick", 16'h0000, 1'b0, 1'b0);
      drive(0, 16'h0000, 0, 0, 0);
      drive(0, 16'h0000, 0, 0, 1);
      check("post_rst_tick2", 16'h0000, 1'b0, 1'b0);

      // ---- randomized run against the reference model ----
      do_reset();
      rc1 = clk_1Hz;
      m_prev = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            check("rand_reset", 16'h0000, 1'b0, 1'b0);
         end else begin
            rld  = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 14) == 0);
            rpa  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0) rc1 = ~rc1;
            rbcd[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rbcd[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rbcd[7:4]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            rbcd[3:0]   = 4'($urandom_range(0, 15));
            drive(rld, rbcd, rst, rpa, rc1);
            model_step(rld, rbcd, rst, rpa, rc1);
            check($sformatf("rand%0d", n), model_bcd(),
                  m_state == M_RUN, m_state == M_DONE);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
